decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decode stage directly downstream of the fetch stage.
- Consumes the fetch latch (PC, IR, valid), reads a 16-entry register file, and tracks in-flight writers in a scoreboard.
- Drives the dependency-stall and branch-stall signals back to fetch.
- Emits a decoded, valid-tagged latch to the execute stage. Writeback returns through a dedicated port.

Parameters:
- PC_WIDTH, 16, program-counter width
- IR_WIDTH, 32, instruction width
- DATA_WIDTH, 16, register data width
- NUM_REGS, 16, architectural registers (index width 4)

Ports:
- I_CLOCK  in  1  clock; all state updates on negedge
- I_LOCK  in  1  asynchronous active-low reset (0 = reset)
- I_PC  in  PC_WIDTH  PC from fetch latch
- I_IR  in  IR_WIDTH  instruction from fetch latch
- I_FE_Valid  in  1  fetch latch holds a real instruction
- I_BranchAddrSelect  in  1  branch resolved this cycle
- I_WB_Valid  in  1  writeback valid
- I_WB_DestReg  in  4  writeback register index
- I_WB_Data  in  DATA_WIDTH  writeback data
- O_DepStallSignal  out  1  to fetch: hold fetch latch (combinational)
- O_BranchStallSignal  out  1  to fetch: branch in flight (combinational)
- O_DE_Valid  out  1  execute latch valid
- O_PC  out  PC_WIDTH  latched PC
- O_Opcode  out  8  latched opcode
- O_DestReg  out  4  latched rd
- O_Src1Value  out  DATA_WIDTH  latched register-file value of rs1
- O_Src2Value  out  DATA_WIDTH  latched register-file value of rs2
- O_Imm  out  16  latched immediate

Behaviour:
- Encoding fields:
  - opcode = IR[31:24]
  - rd = IR[23:20]
  - rs1 = IR[19:16]
  - rs2 = IR[11:8]
  - imm = IR[15:0]
- Opcode classes:
  - 0x00-0x1F ALU: reads rs1/rs2, writes rd
  - 0x20-0x3F branch: reads rs1, no write
  - 0x40 LD: reads rs1, writes rd
  - 0x41 ST: reads rs1/rs2, no write
  - 0xFF and all other opcodes: NOP, no reads/writes, never stalls
- Reset (I_LOCK=0, asynchronous):
  - All register-file entries, scoreboard bits, and outputs cleared to 0.
  - O_Opcode = 8'hFF.
  - FSM goes to RUN.
  - Takes effect mid-operation regardless of clock.
- Register file:
  - Writeback is written on negedge when I_WB_Valid=1.
  - Same-cycle read of the written index returns I_WB_Data (write-before-read bypass).
- Scoreboard: busy[NUM_REGS].
  - Set on issue of a writing instruction to its rd.
  - Cleared by I_WB_Valid at I_WB_DestReg.
  - Simultaneous set and clear of the same index: set wins.
- Effective busy for hazard check: busy[r] & ~(I_WB_Valid & I_WB_DestReg==r), i.e. a same-cycle writeback removes the hazard.
- O_DepStallSignal = I_FE_Valid & state==RUN & (effective busy on any used source, or on rd for writing opcodes, which covers WAW).
- FSM states:
  - RUN -> BR_WAIT: on issue of a valid branch.
  - BR_WAIT -> RUN: on I_BranchAddrSelect=1.
  - Other inputs ignored in BR_WAIT.
- O_BranchStallSignal = (state==BR_WAIT & ~I_BranchAddrSelect) | (state==RUN & I_FE_Valid & branch opcode & ~O_DepStallSignal).
- Issue condition: state==RUN & I_FE_Valid & ~O_DepStallSignal.
  - On negedge, all O_* latch fields update and O_DE_Valid=1.
  - Otherwise O_DE_Valid=0, O_Opcode=8'hFF, and the other fields hold.
- Instructions presented during BR_WAIT are discarded (bubble).
- Latency: one negedge from valid fetch latch to execute latch when no stall.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- Defined: adds outputs O_DepStallCnt[15:0] and O_BrStallCnt[15:0].
  - Each counts negedges with the respective stall asserted.
  - Counters saturate at 16'hFFFF and are reset to 0 by I_LOCK.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: I_LOCK=0 asynchronously mid-cycle -> all outputs 0, O_Opcode=8'hFF, busy all clear; release, IR=32'h0012_3400 valid -> next negedge O_DE_Valid=1, O_DestReg=1, O_Opcode=0x00.
- RAW: issue ALU writing r1, then ALU reading rs1=r1 -> O_DepStallSignal=1 and O_DE_Valid=0 each cycle until WB(r1, 16'h00AB); that cycle stall drops, issue with O_Src1Value=16'h00AB.
- Branch: valid IR opcode 0x20 -> O_BranchStallSignal=1 same cycle; FSM BR_WAIT; valid ALU in-flight dropped (O_DE_Valid=0); I_BranchAddrSelect=1 -> stall low that cycle; next instruction issues following edge.
- WAW/same-cycle: issue writer to r3 while WB to r3 the same negedge -> busy[3] remains 1; a subsequent reader of r3 stalls.
- NOP: IR=32'hFF000000 with all registers busy -> no stall, O_DE_Valid=1, O_Opcode=0xFF.
- DECODE_PERF_CNT_EN: 5-cycle dependency stall then 3-cycle branch wait -> O_DepStallCnt=5, O_BrStallCnt=3; force 70000 stall cycles -> counter holds 16'hFFFF.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch/writeback inputs and execute-latch outputs of the decode stage.
// O_DepStallCnt/O_BrStallCnt exist only when DECODE_PERF_CNT_EN is defined.
interface decode_stage_if #(
  parameter int PC_WIDTH   = 16,
  parameter int IR_WIDTH   = 32,
  parameter int DATA_WIDTH = 16
);
  logic [PC_WIDTH-1:0]   I_PC;
  logic [IR_WIDTH-1:0]   I_IR;
  logic                  I_FE_Valid;
  logic                  I_BranchAddrSelect;
  logic                  I_WB_Valid;
  logic [3:0]            I_WB_DestReg;
  logic [DATA_WIDTH-1:0] I_WB_Data;
  logic                  O_DepStallSignal;
  logic                  O_BranchStallSignal;
  logic                  O_DE_Valid;
  logic [PC_WIDTH-1:0]   O_PC;
  logic [7:0]            O_Opcode;
  logic [3:0]            O_DestReg;
  logic [DATA_WIDTH-1:0] O_Src1Value;
  logic [DATA_WIDTH-1:0] O_Src2Value;
  logic [15:0]           O_Imm;
`ifdef DECODE_PERF_CNT_EN
  logic [15:0]           O_DepStallCnt;
  logic [15:0]           O_BrStallCnt;
`endif
  modport master (
    output I_PC, I_IR, I_FE_Valid, I_BranchAddrSelect, I_WB_Valid, I_WB_DestReg, I_WB_Data,
`ifdef DECODE_PERF_CNT_EN
    input  O_DepStallCnt, O_BrStallCnt,
`endif
    input  O_DepStallSignal, O_BranchStallSignal, O_DE_Valid, O_PC, O_Opcode, O_DestReg,
           O_Src1Value, O_Src2Value, O_Imm
  );
  modport slave (
    input  I_PC, I_IR, I_FE_Valid, I_BranchAddrSelect, I_WB_Valid, I_WB_DestReg, I_WB_Data,
`ifdef DECODE_PERF_CNT_EN
    output O_DepStallCnt, O_BrStallCnt,
`endif
    output O_DepStallSignal, O_BranchStallSignal, O_DE_Valid, O_PC, O_Opcode, O_DestReg,
           O_Src1Value, O_Src2Value, O_Imm
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: decode, register file and busy scoreboard between fetch and execute; negedge-clocked.
// Define DECODE_PERF_CNT_EN to add saturating dependency/branch stall counters.
module decode_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16
) (
  input logic           I_CLOCK,
  input logic           I_LOCK,
  decode_stage_if.slave bus
);
  typedef enum logic {RUN, BR_WAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] opcode;
  logic [3:0] rd, rs1, rs2;
  logic is_alu, is_br, is_ld, is_st, uses1, uses2, writes;
  logic [NUM_REGS-1:0] busy, wb_hit, set_mask, eff_busy;
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic [DATA_WIDTH-1:0] src1, src2;
  logic dep_stall, br_stall, issue;
  assign opcode = bus.I_IR[31:24];
  assign rd     = bus.I_IR[23:20];
  assign rs1    = bus.I_IR[19:16];
  assign rs2    = bus.I_IR[11:8];
  assign is_alu = opcode[7:5] == 3'b000;
  assign is_br  = opcode[7:5] == 3'b001;
  assign is_ld  = opcode == 8'h40;
  assign is_st  = opcode == 8'h41;
  assign uses1  = is_alu | is_br | is_ld | is_st;
  assign uses2  = is_alu | is_st;
  assign writes = is_alu | is_ld;
  always_comb begin
    wb_hit   = '0;
    set_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wb_hit[r]   = bus.I_WB_Valid && bus.I_WB_DestReg == 4'(r);
      set_mask[r] = issue && writes && rd == 4'(r);
    end
  end
  // a writeback landing this cycle already resolves the hazard
  assign eff_busy  = busy & ~wb_hit;
  assign dep_stall = bus.I_FE_Valid && state_q == RUN &&
                     ((uses1 && eff_busy[rs1]) || (uses2 && eff_busy[rs2]) || (writes && eff_busy[rd]));
  assign issue     = state_q == RUN && bus.I_FE_Valid && !dep_stall;
  assign br_stall  = (state_q == BR_WAIT && !bus.I_BranchAddrSelect) ||
                     (state_q == RUN && bus.I_FE_Valid && is_br && !dep_stall);
  assign src1      = wb_hit[rs1] ? bus.I_WB_Data : rf[rs1];
  assign src2      = wb_hit[rs2] ? bus.I_WB_Data : rf[rs2];
  assign bus.O_DepStallSignal    = dep_stall;
  assign bus.O_BranchStallSignal = br_stall;
  always_comb begin
    state_d = state_q;
    if (state_q == RUN)
      state_d = (issue && is_br) ? BR_WAIT : RUN;
    else
      state_d = bus.I_BranchAddrSelect ? RUN : BR_WAIT;
  end
  always_ff @(negedge I_CLOCK or negedge I_LOCK)
    if (!I_LOCK) state_q <= RUN;
    else state_q <= state_d;
  always_ff @(negedge I_CLOCK or negedge I_LOCK)
    if (!I_LOCK) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else if (bus.I_WB_Valid) begin
      rf[bus.I_WB_DestReg] <= bus.I_WB_Data;
    end
  // set after clear so a same-index issue keeps the register busy
  always_ff @(negedge I_CLOCK or negedge I_LOCK)
    if (!I_LOCK) busy <= '0;
    else busy <= (busy & ~wb_hit) | set_mask;
  always_ff @(negedge I_CLOCK or negedge I_LOCK)
    if (!I_LOCK) begin
      bus.O_DE_Valid  <= 1'b0;
      bus.O_PC        <= '0;
      bus.O_Opcode    <= 8'hFF;
      bus.O_DestReg   <= '0;
      bus.O_Src1Value <= '0;
      bus.O_Src2Value <= '0;
      bus.O_Imm       <= '0;
    end else if (issue) begin
      bus.O_DE_Valid  <= 1'b1;
      bus.O_PC        <= bus.I_PC;
      bus.O_Opcode    <= opcode;
      bus.O_DestReg   <= rd;
      bus.O_Src1Value <= src1;
      bus.O_Src2Value <= src2;
      bus.O_Imm       <= bus.I_IR[15:0];
    end else begin
      bus.O_DE_Valid  <= 1'b0;
      bus.O_Opcode    <= 8'hFF;
    end
`ifdef DECODE_PERF_CNT_EN
  always_ff @(negedge I_CLOCK or negedge I_LOCK)
    if (!I_LOCK) begin
      bus.O_DepStallCnt <= '0;
      bus.O_BrStallCnt  <= '0;
    end else begin
      if (dep_stall && bus.O_DepStallCnt != 16'hFFFF) bus.O_DepStallCnt <= bus.O_DepStallCnt + 16'd1;
      if (br_stall && bus.O_BrStallCnt != 16'hFFFF) bus.O_BrStallCnt <= bus.O_BrStallCnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven cycle vectors with a scoreboard queue, plus async-reset and counter sequences.
module tb_decode_stage;
  typedef struct {
    logic fe; logic [15:0] pc; logic [31:0] ir; logic bas;
    logic wbv; logic [3:0] wbd; logic [15:0] wbdat;
    logic dep; logic br; logic dv; logic [7:0] op; logic [3:0] dest;
    logic [15:0] s1; logic [15:0] s2; logic [15:0] imm;
  } vec_t;
  logic clk = 1'b1;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t sb[$];
  vec_t tbl[27];
  always #5 clk = ~clk;
  decode_stage_if bus();
  decode_stage dut (.I_CLOCK(clk), .I_LOCK(rst_n), .bus(bus));
  function automatic vec_t mk(logic fe, logic [15:0] pc, logic [31:0] ir, logic bas,
                              logic wbv, logic [3:0] wbd, logic [15:0] wbdat,
                              logic dep, logic br, logic dv, logic [7:0] op, logic [3:0] dest,
                              logic [15:0] s1, logic [15:0] s2, logic [15:0] imm);
    vec_t v;
    v.fe = fe; v.pc = pc; v.ir = ir; v.bas = bas; v.wbv = wbv; v.wbd = wbd; v.wbdat = wbdat;
    v.dep = dep; v.br = br; v.dv = dv; v.op = op; v.dest = dest; v.s1 = s1; v.s2 = s2; v.imm = imm;
    return v;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    bus.I_FE_Valid = v.fe; bus.I_PC = v.pc; bus.I_IR = v.ir; bus.I_BranchAddrSelect = v.bas;
    bus.I_WB_Valid = v.wbv; bus.I_WB_DestReg = v.wbd; bus.I_WB_Data = v.wbdat;
    sb.push_back(v);
    #2;
    chk({tag, " dep_stall"}, 32'(bus.O_DepStallSignal), 32'(v.dep));
    chk({tag, " br_stall"}, 32'(bus.O_BranchStallSignal), 32'(v.br));
    @(negedge clk); #1;
    e = sb.pop_front();
    chk({tag, " de_valid"}, 32'(bus.O_DE_Valid), 32'(e.dv));
    chk({tag, " opcode"}, 32'(bus.O_Opcode), 32'(e.op));
    if (e.dv) begin
      chk({tag, " pc"}, 32'(bus.O_PC), 32'(e.pc));
      chk({tag, " dest"}, 32'(bus.O_DestReg), 32'(e.dest));
      chk({tag, " src1"}, 32'(bus.O_Src1Value), 32'(e.s1));
      chk({tag, " src2"}, 32'(bus.O_Src2Value), 32'(e.s2));
      chk({tag, " imm"}, 32'(bus.O_Imm), 32'(e.imm));
    end
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, " de_valid"}, 32'(bus.O_DE_Valid), 32'h0);
    chk({tag, " opcode"}, 32'(bus.O_Opcode), 32'hFF);
    chk({tag, " pc"}, 32'(bus.O_PC), 32'h0);
    chk({tag, " dest"}, 32'(bus.O_DestReg), 32'h0);
    chk({tag, " src1"}, 32'(bus.O_Src1Value), 32'h0);
    chk({tag, " src2"}, 32'(bus.O_Src2Value), 32'h0);
    chk({tag, " imm"}, 32'(bus.O_Imm), 32'h0);
  endtask
  initial begin
    tbl[0]  = mk(0, 16'h0000, 32'h0000_0000, 0, 1, 2, 16'h1234, 0, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[1]  = mk(0, 16'h0000, 32'h0000_0000, 0, 1, 4, 16'h5555, 0, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[2]  = mk(1, 16'h0010, 32'h0012_3400, 0, 0, 0, 16'h0000, 0, 0, 1, 8'h00, 1, 16'h1234, 16'h5555, 16'h3400);
    tbl[3]  = mk(1, 16'h0014, 32'h0051_0000, 0, 0, 0, 16'h0000, 1, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[4]  = mk(1, 16'h0014, 32'h0051_0000, 0, 0, 0, 16'h0000, 1, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[5]  = mk(1, 16'h0014, 32'h0051_0000, 0, 1, 1, 16'h00AB, 0, 0, 1, 8'h00, 5, 16'h00AB, 16'h0000, 16'h0000);
    tbl[6]  = mk(1, 16'h0018, 32'h0030_0000, 0, 1, 3, 16'h0777, 0, 0, 1, 8'h00, 3, 16'h0000, 16'h0000, 16'h0000);
    tbl[7]  = mk(1, 16'h001C, 32'h0063_0000, 0, 0, 0, 16'h0000, 1, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[8]  = mk(1, 16'h001C, 32'h0063_0000, 0, 1, 3, 16'h0999, 0, 0, 1, 8'h00, 6, 16'h0999, 16'h0000, 16'h0000);
    tbl[9]  = mk(1, 16'h0020, 32'hFF52_0400, 0, 0, 0, 16'h0000, 0, 0, 1, 8'hFF, 5, 16'h1234, 16'h5555, 16'h0400);
    tbl[10] = mk(1, 16'h0024, 32'h2002_0000, 0, 0, 0, 16'h0000, 0, 1, 1, 8'h20, 0, 16'h1234, 16'h0000, 16'h0000);
    tbl[11] = mk(1, 16'h0028, 32'h0070_0000, 0, 0, 0, 16'h0000, 0, 1, 0, 8'hFF, 0, 0, 0, 0);
    tbl[12] = mk(1, 16'h0028, 32'h0070_0000, 1, 0, 0, 16'h0000, 0, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[13] = mk(1, 16'h002C, 32'h0070_0000, 0, 0, 0, 16'h0000, 0, 0, 1, 8'h00, 7, 16'h0000, 16'h0000, 16'h0000);
    tbl[14] = mk(1, 16'h0030, 32'h4081_0004, 0, 0, 0, 16'h0000, 0, 0, 1, 8'h40, 8, 16'h00AB, 16'h0000, 16'h0004);
    tbl[15] = mk(1, 16'h0034, 32'h4109_0800, 0, 0, 0, 16'h0000, 1, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[16] = mk(1, 16'h0034, 32'h4109_0800, 0, 1, 8, 16'h4242, 0, 0, 1, 8'h41, 0, 16'h0000, 16'h4242, 16'h0800);
    tbl[17] = mk(1, 16'h0038, 32'h4150_2000, 0, 0, 0, 16'h0000, 0, 0, 1, 8'h41, 5, 16'h0000, 16'h0000, 16'h2000);
    tbl[18] = mk(1, 16'h003C, 32'h0060_0000, 0, 0, 0, 16'h0000, 1, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[19] = mk(1, 16'h0040, 32'h2006_0000, 0, 0, 0, 16'h0000, 1, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[20] = mk(0, 16'h0000, 32'h0000_0000, 0, 1, 6, 16'h0066, 0, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[21] = mk(1, 16'h0044, 32'h0000_5500, 0, 0, 0, 16'h0000, 1, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[22] = mk(1, 16'h0048, 32'h4282_8400, 0, 0, 0, 16'h0000, 0, 0, 1, 8'h42, 8, 16'h1234, 16'h5555, 16'h8400);
    tbl[23] = mk(1, 16'h004C, 32'h1F50_0000, 0, 0, 0, 16'h0000, 1, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[24] = mk(1, 16'h0050, 32'h3F02_0000, 0, 0, 0, 16'h0000, 0, 1, 1, 8'h3F, 0, 16'h1234, 16'h0000, 16'h0000);
    tbl[25] = mk(0, 16'h0000, 32'h0000_0000, 1, 0, 0, 16'h0000, 0, 0, 0, 8'hFF, 0, 0, 0, 0);
    tbl[26] = mk(1, 16'h0054, 32'h1F96_8800, 0, 0, 0, 16'h0000, 0, 0, 1, 8'h1F, 9, 16'h0066, 16'h4242, 16'h8800);
    bus.I_FE_Valid = 0; bus.I_PC = '0; bus.I_IR = '0; bus.I_BranchAddrSelect = 0;
    bus.I_WB_Valid = 0; bus.I_WB_DestReg = '0; bus.I_WB_Data = '0;
    #12;
    chk_cleared("reset");
    chk("reset dep_stall", 32'(bus.O_DepStallSignal), 32'h0);
    chk("reset br_stall", 32'(bus.O_BranchStallSignal), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 27; i++) apply($sformatf("row%0d", i), tbl[i]);
    // asynchronous reset between edges wipes the last issued latch, regfile and scoreboard
    bus.I_FE_Valid = 1; bus.I_IR = 32'h0051_0000; bus.I_PC = 16'h0060;
    #2 rst_n = 1'b0;
    #1 chk_cleared("midreset");
    rst_n = 1'b1;
    apply("post_rst_a", mk(1, 16'h0060, 32'h0051_0000, 0, 0, 0, 0, 0, 0, 1, 8'h00, 5, 16'h0000, 16'h0000, 16'h0000));
    apply("post_rst_b", mk(1, 16'h0064, 32'h0012_3400, 0, 0, 0, 0, 0, 0, 1, 8'h00, 1, 16'h0000, 16'h0000, 16'h3400));
`ifdef DECODE_PERF_CNT_EN
    chk("cnt_dep0", 32'(bus.O_DepStallCnt), 32'd0);
    for (int i = 0; i < 5; i++)
      apply($sformatf("pdep%0d", i), mk(1, 16'h0068, 32'h0021_0000, 0, 0, 0, 0, 1, 0, 0, 8'hFF, 0, 0, 0, 0));
    apply("pdep_go", mk(1, 16'h0068, 32'h0021_0000, 0, 1, 1, 16'h0001, 0, 0, 1, 8'h00, 2, 16'h0001, 16'h0000, 16'h0000));
    apply("pbr0", mk(1, 16'h006C, 32'h2000_0000, 0, 0, 0, 0, 0, 1, 1, 8'h20, 0, 16'h0000, 16'h0000, 16'h0000));
    apply("pbr1", mk(0, 16'h0000, 32'h0000_0000, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 0, 0, 0, 0));
    apply("pbr2", mk(0, 16'h0000, 32'h0000_0000, 0, 0, 0, 0, 0, 1, 0, 8'hFF, 0, 0, 0, 0));
    apply("pbr3", mk(0, 16'h0000, 32'h0000_0000, 1, 0, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0));
    chk("cnt_dep5", 32'(bus.O_DepStallCnt), 32'd5);
    chk("cnt_br3", 32'(bus.O_BrStallCnt), 32'd3);
    apply("psat", mk(1, 16'h0070, 32'h0002_0000, 0, 0, 0, 0, 1, 0, 0, 8'hFF, 0, 0, 0, 0));
    repeat (70000) @(negedge clk);
    #1;
    chk("cnt_dep_sat", 32'(bus.O_DepStallCnt), 32'hFFFF);
    chk("cnt_br_hold", 32'(bus.O_BrStallCnt), 32'd3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
